key_lookup_table: RTL and testbench
===================================

// Module: key_lookup_table
// PURPOSE
//   Runtime-programmable key->data lookup table with a registered, handshaked result stage.
//   Successor to the combinational key mux templates: entries are written at run time,
//   hits resolve by priority and report the matched index, and lookups flow through a
//   valid/ready pipeline stage. Used in npc for decode/CSR-address tables that change at run time.
// PARAMETERS
//   NR_KEY      4   number of table entries (>=2); IDX_W = $clog2(NR_KEY)
//   KEY_LEN     2   key width in bits
//   DATA_LEN    8   data width in bits
//   HAS_DEFAULT 1   1: a miss returns default_out; 0: a miss returns all-zero data
// PORTS
//   clk          in   1         clock, rising edge
//   rst          in   1         asynchronous reset, active-high
//   wr_en        in   1         write one table entry this cycle
//   wr_idx       in   IDX_W     entry index to write
//   wr_key       in   KEY_LEN   key stored in the entry
//   wr_data      in   DATA_LEN  data stored in the entry
//   wr_vld       in   1         valid bit stored in the entry (0 = invalidate)
//   clr_all      in   1         invalidate every entry
//   default_out  in   DATA_LEN  miss value, used only when HAS_DEFAULT=1
//   in_valid     in   1         lookup request valid
//   in_ready     out  1         lookup request accepted when in_valid && in_ready
//   in_key       in   KEY_LEN   lookup key
//   out_valid    out  1         result valid
//   out_ready    in   1         result consumed when out_valid && out_ready
//   out_data     out  DATA_LEN  looked-up data
//   out_hit      out  1         at least one valid entry matched
//   out_idx      out  IDX_W     lowest matching index (0 on miss)
//   out_multi    out  1         two or more valid entries matched
// BEHAVIOUR
//   Reset (async, immediate): all entry valid bits, keys and data = 0; out_valid=0,
//     out_data=0, out_hit=0, out_idx=0, out_multi=0. A pending result is dropped.
//   Table: per entry {vld, key, data} registers. wr_en updates entry wr_idx at the clock edge.
//     wr_idx >= NR_KEY: write ignored. clr_all clears all vld bits; clr_all and wr_en in the
//     same cycle: clear first, then the write lands (the written entry takes wr_vld).
//   Match: entry i matches when vld[i] && key[i]==in_key. Lowest matching index wins;
//     out_data = data of that entry, with no OR-merging of multiple hits.
//   Miss: out_hit=0, out_idx=0, out_data = HAS_DEFAULT ? default_out (sampled at accept) : 0.
//   Output stage FSM, 2 states: EMPTY (out_valid=0) / FULL (out_valid=1).
//     in_ready = !out_valid || out_ready (combinational; pass-through when draining).
//     EMPTY + accept -> FULL.  FULL + consume, no accept -> EMPTY.
//     FULL + consume + accept -> FULL with the new result (back-to-back, 1 lookup/cycle).
//     FULL + !out_ready: every out_* held stable, in_ready=0.
//   Latency: result visible exactly 1 cycle after the accept edge.
//   Write/lookup same cycle: the lookup uses the table contents from before the write.
//     A later table write does not change a result already held in the output stage.
//   Output flags are registered; none depend combinationally on in_key or the table.
// TESTING
//   1. Reset, then lookup key 2 -> out_valid 1 cycle later, out_hit=0, out_data=default_out (0x5A).
//   2. Write idx1={vld,key=2,data=0x33}; next cycle look up 2 -> out_hit=1, out_idx=1, out_data=0x33.
//   3. idx0 and idx3 both key=1, data 0x11/0x44 -> out_data=0x11, out_idx=0, out_multi=1.
//   4. Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs unchanged;
//      release -> back-to-back results, one per cycle, in order.
//   5. Write idx2 key=3 in the same cycle as a lookup of 3 -> miss; the next lookup of 3 -> hit.
//   6. clr_all with wr_en idx0 in the same cycle -> only idx0 hits. Assert rst while FULL ->
//      out_valid=0 at once, and all earlier entries miss.

Source files
------------

// File: rtl/key_lookup_table.sv
// key_lookup_table: run-time programmable key->data table. A lookup resolves by
// priority (lowest valid matching entry wins) and its result is registered in a
// single valid/ready output stage, so results appear one cycle after acceptance.
module key_lookup_table #(
    parameter int NR_KEY      = 4,
    parameter int KEY_LEN     = 2,
    parameter int DATA_LEN    = 8,
    parameter int HAS_DEFAULT = 1,
    localparam int IDX_W      = $clog2(NR_KEY)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IDX_W-1:0]    wr_idx,
    input  logic [KEY_LEN-1:0]  wr_key,
    input  logic [DATA_LEN-1:0] wr_data,
    input  logic                wr_vld,
    input  logic                clr_all,
    input  logic [DATA_LEN-1:0] default_out,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [KEY_LEN-1:0]  in_key,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_data,
    output logic                out_hit,
    output logic [IDX_W-1:0]    out_idx,
    output logic                out_multi
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state_reg, state_next;

    logic [NR_KEY-1:0]   match;
    logic [DATA_LEN-1:0] entry_data [NR_KEY];

    logic                accept;
    logic [DATA_LEN-1:0] data_next;
    logic                hit_next;
    logic [IDX_W-1:0]    idx_next;
    logic                multi_next;

    logic [DATA_LEN-1:0] out_data_reg;
    logic                out_hit_reg;
    logic [IDX_W-1:0]    out_idx_reg;
    logic                out_multi_reg;

    // One storage slot per entry. An out-of-range wr_idx equals no entry index,
    // so such writes fall through without touching the table.
    generate
        for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_entry
            logic                vld_reg;
            logic [KEY_LEN-1:0]  key_reg;
            logic [DATA_LEN-1:0] data_reg;
            logic                sel;

            assign sel = wr_en && (wr_idx == IDX_W'(gi));

            // Entry update: a targeted write overrides a simultaneous clear-all.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    vld_reg  <= 1'b0;
                    key_reg  <= '0;
                    data_reg <= '0;
                end else if (sel) begin
                    vld_reg  <= wr_vld;
                    key_reg  <= wr_key;
                    data_reg <= wr_data;
                end else if (clr_all) begin
                    vld_reg  <= 1'b0;
                end
            end

            assign match[gi]      = vld_reg && (key_reg == in_key);
            assign entry_data[gi] = data_reg;
        end
    endgenerate

    // Priority resolve: scan high to low so the lowest match lands last;
    // any second match seen flags a multi-hit.
    always_comb begin
        hit_next   = 1'b0;
        idx_next   = '0;
        multi_next = 1'b0;
        data_next  = (HAS_DEFAULT != 0) ? default_out : '0;
        for (int i = NR_KEY - 1; i >= 0; i--) begin
            if (match[i]) begin
                if (hit_next) begin
                    multi_next = 1'b1;
                end
                hit_next  = 1'b1;
                idx_next  = IDX_W'(i);
                data_next = entry_data[i];
            end
        end
    end

    assign out_valid = (state_reg == FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;

    // Output stage next state: fill on accept, empty on consume without refill.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (accept) state_next = FULL;
            FULL:  if (out_ready && !accept) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    // State register for the output stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Result registers load only on accept, so a stalled result stays frozen
    // and later table writes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_hit_reg   <= 1'b0;
            out_idx_reg   <= '0;
            out_multi_reg <= 1'b0;
        end else if (accept) begin
            out_data_reg  <= data_next;
            out_hit_reg   <= hit_next;
            out_idx_reg   <= idx_next;
            out_multi_reg <= multi_next;
        end
    end

    assign out_data  = out_data_reg;
    assign out_hit   = out_hit_reg;
    assign out_idx   = out_idx_reg;
    assign out_multi = out_multi_reg;

endmodule

// File: tb/tb_key_lookup_table.sv
// Testbench for key_lookup_table: directed scenarios followed by random traffic,
// all checked against a behavioural model of the table and the output stage.
module tb_key_lookup_table;

    localparam int NR_KEY   = 4;
    localparam int KEY_LEN  = 2;
    localparam int DATA_LEN = 8;
    localparam int IDX_W    = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [KEY_LEN-1:0]  wr_key;
    logic [DATA_LEN-1:0] wr_data;
    logic                wr_vld;
    logic                clr_all;
    logic [DATA_LEN-1:0] default_out;
    logic                in_valid;
    logic                in_ready;
    logic [KEY_LEN-1:0]  in_key;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_LEN-1:0] out_data;
    logic                out_hit;
    logic [IDX_W-1:0]    out_idx;
    logic                out_multi;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    bit       m_vld  [NR_KEY];
    bit [1:0] m_key  [NR_KEY];
    bit [7:0] m_data [NR_KEY];
    bit       e_valid;
    bit [7:0] e_data;
    bit       e_hit;
    bit [1:0] e_idx;
    bit       e_multi;

    key_lookup_table #(
        .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .HAS_DEFAULT(1)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_key(wr_key), .wr_data(wr_data),
        .wr_vld(wr_vld), .clr_all(clr_all), .default_out(default_out),
        .in_valid(in_valid), .in_ready(in_ready), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_hit(out_hit), .out_idx(out_idx), .out_multi(out_multi)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR_KEY; i++) begin
            m_vld[i] = 0; m_key[i] = 0; m_data[i] = 0;
        end
        e_valid = 0; e_data = 0; e_hit = 0; e_idx = 0; e_multi = 0;
    endtask

    // Count every valid entry holding the key; the first one found supplies the data.
    task automatic ref_lookup(input bit [1:0] k, input bit [7:0] dflt,
                              output bit [7:0] d, output bit h, output bit [1:0] ix,
                              output bit mu);
        int n = 0;
        d = dflt; h = 0; ix = 0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (m_vld[i] && m_key[i] == k) begin
                if (n == 0) begin
                    h = 1; ix = 2'(i); d = m_data[i];
                end
                n++;
            end
        end
        mu = (n >= 2);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, 32'(out_valid), 32'(e_valid));
        check({tag, ".out_data"},  32'(out_data),  32'(e_data));
        check({tag, ".out_hit"},   32'(out_hit),   32'(e_hit));
        check({tag, ".out_idx"},   32'(out_idx),   32'(e_idx));
        check({tag, ".out_multi"}, 32'(out_multi), 32'(e_multi));
    endtask

    // One clock cycle with the inputs currently driven; advances the model alongside.
    task automatic cycle(input string tag);
        bit acc, h, mu;
        bit [7:0] d;
        bit [1:0] ix;
        #1;
        check({tag, ".in_ready"}, 32'(in_ready), 32'(!e_valid || out_ready));
        acc = in_valid && (!e_valid || out_ready);
        ref_lookup(in_key, default_out, d, h, ix, mu);
        @(posedge clk);
        if (acc) begin
            e_valid = 1; e_data = d; e_hit = h; e_idx = ix; e_multi = mu;
        end else if (e_valid && out_ready) begin
            e_valid = 0;
        end
        if (clr_all) for (int i = 0; i < NR_KEY; i++) m_vld[i] = 0;
        if (wr_en && int'(wr_idx) < NR_KEY) begin
            m_vld[wr_idx] = wr_vld; m_key[wr_idx] = wr_key; m_data[wr_idx] = wr_data;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic idle();
        wr_en = 0; clr_all = 0; in_valid = 0; out_ready = 1;
    endtask

    task automatic write(input bit [1:0] idx, input bit [1:0] k, input bit [7:0] d, input bit v);
        wr_en = 1; wr_idx = idx; wr_key = k; wr_data = d; wr_vld = v;
    endtask

    initial begin
        rst = 1; wr_en = 0; wr_idx = 0; wr_key = 0; wr_data = 0; wr_vld = 0;
        clr_all = 0; default_out = 8'h5A; in_valid = 0; in_key = 0; out_ready = 1;
        model_reset();
        #1;
        check_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst = 0;

        // 1: lookup on an empty table misses and returns the default
        idle(); in_valid = 1; in_key = 2;
        cycle("t1_lookup");
        check("t1.data_5a", 32'(out_data), 32'h5A);
        check("t1.hit0",    32'(out_hit),  32'h0);
        idle(); cycle("t1_drain");

        // 2: single entry hit
        idle(); write(1, 2, 8'h33, 1); cycle("t2_write");
        idle(); in_valid = 1; in_key = 2; cycle("t2_lookup");
        check("t2.data_33", 32'(out_data), 32'h33);
        check("t2.idx1",    32'(out_idx),  32'h1);

        // 3: two matches, lowest index wins, multi flagged
        idle(); write(0, 1, 8'h11, 1); cycle("t3_w0");
        idle(); write(3, 1, 8'h44, 1); cycle("t3_w3");
        idle(); in_valid = 1; in_key = 1; cycle("t3_lookup");
        check("t3.data_11", 32'(out_data),  32'h11);
        check("t3.multi",   32'(out_multi), 32'h1);

        // 4: stall for three cycles, then back-to-back drain
        idle(); in_valid = 1; in_key = 2; cycle("t4_fill");
        out_ready = 0; in_key = 1;
        for (int i = 0; i < 3; i++) cycle("t4_stall");
        check("t4.stall_ready0", 32'(in_ready), 32'h0);
        out_ready = 1;
        in_key = 1; cycle("t4_b2b_a");
        in_key = 3; cycle("t4_b2b_b");
        in_key = 2; cycle("t4_b2b_c");
        idle(); cycle("t4_drain");

        // 5: write and lookup in the same cycle see the old table
        idle(); write(2, 3, 8'h99, 1); in_valid = 1; in_key = 3; cycle("t5_same");
        check("t5.miss", 32'(out_hit), 32'h0);
        idle(); in_valid = 1; in_key = 3; cycle("t5_next");
        check("t5.hit_idx2", 32'(out_idx), 32'h2);

        // 6: clear-all with a simultaneous write keeps only the written entry
        idle(); clr_all = 1; write(0, 0, 8'h77, 1); cycle("t6_clr");
        idle(); in_valid = 1; in_key = 0; cycle("t6_hit0");
        in_key = 2; cycle("t6_miss2");
        check("t6.miss2", 32'(out_hit), 32'h0);

        // 6b: asynchronous reset while FULL and stalled
        idle(); in_valid = 1; in_key = 0; out_ready = 0; cycle("t6_full");
        idle(); out_ready = 0;
        #2 rst = 1;
        #1;
        model_reset();
        check_outputs("t6_async_rst");
        @(posedge clk); #1;
        rst = 0;
        idle(); in_valid = 1;
        for (int k = 0; k < 4; k++) begin
            in_key = 2'(k); cycle("t6_post_rst");
        end
        idle(); cycle("t6_drain");

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            wr_en     = ($urandom_range(0, 3) == 0);
            wr_idx    = 2'($urandom);
            wr_key    = 2'($urandom);
            wr_data   = 8'($urandom);
            wr_vld    = ($urandom_range(0, 3) != 0);
            clr_all   = ($urandom_range(0, 15) == 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            in_key    = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) default_out = 8'($urandom);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
